// File: rtl/spi_pkg.sv
// Types and default frame geometry shared by the SPI master and slave sides.
package spi_pkg;

    localparam int unsigned SpiDataWidth = 16;
    localparam int unsigned SpiClkDiv    = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold,
        StGap
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Control handshake and SPI pin bundle; master is the controller's view, slave its partner's.
interface spi_master_if #(
    parameter int unsigned DATA_WIDTH = spi_pkg::SpiDataWidth
) ();

    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;
    logic                  SCLK;
    logic                  SSEL;
    logic                  MOSI;
    logic                  MISO;

    modport master (
        input  start, tx_data, MISO,
        output rx_data, busy, done, SCLK, SSEL, MOSI
    );

    modport slave (
        output start, tx_data, MISO,
        input  rx_data, busy, done, SCLK, SSEL, MOSI
    );

endinterface

// File: rtl/spi_clk_div.sv
// Free-running CLK_DIV terminal-count tick generator with synchronous clear.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = spi_pkg::SpiClkDiv
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || (cnt_q == LastCnt)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LastCnt);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one full-duplex MSB-first frame per accepted start pulse.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SpiDataWidth,
    parameter int unsigned CLK_DIV    = SpiClkDiv
) (
    input  logic         FPGA_clk,
    input  logic         FPGA_rst,
    spi_master_if.master bus_io
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  ssel_q, ssel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  div_clear;

    // Holding the divider cleared in idle aligns every timed state to the accepting edge.
    assign div_clear = (state_q == StIdle);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk_i  (FPGA_clk),
        .rst_i  (FPGA_rst),
        .clear_i(div_clear),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        ssel_d    = ssel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    tx_sh_d   = bus_io.tx_data;
                    bit_cnt_d = '0;
                    ssel_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (tick) begin
                    sclk_d  = 1'b0;
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], bus_io.MISO};
                    tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                    state_d = StLow;
                end
            end
            StLow: begin
                // The final bit keeps its low half-period before HOLD, giving SSEL its
                // full (2*DATA_WIDTH+2)*CLK_DIV low time.
                if (tick) begin
                    if (bit_cnt_q == LastBit) begin
                        state_d = StHold;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sclk_d    = 1'b1;
                        state_d   = StHigh;
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    ssel_d    = 1'b1;
                    tx_sh_d   = '0;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
        if (FPGA_rst) begin
            state_q   <= StIdle;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            ssel_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            ssel_q    <= ssel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus_io.SCLK    = sclk_q;
    assign bus_io.SSEL    = ssel_q;
    assign bus_io.MOSI    = tx_sh_q[DATA_WIDTH-1];
    assign bus_io.busy    = busy_q;
    assign bus_io.done    = done_q;
    assign bus_io.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: 16-bit/div-4 and 8-bit/div-2 instances against a cycle-index model.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_WIDTH(16)) if_a ();
    spi_master_if #(.DATA_WIDTH(8))  if_b ();

    logic        loop_a;
    logic [15:0] slv_word;
    logic [4:0]  sidx = 5'd16;
    logic        slv_bit;
    logic        sclk_p = 1'b0;
    logic        ssel_p = 1'b1;

    assign if_a.MISO = loop_a ? if_a.MOSI : slv_bit;
    assign if_b.MISO = if_b.MOSI;

    spi_master #(.DATA_WIDTH(16), .CLK_DIV(4)) u_a (
        .FPGA_clk(clk),
        .FPGA_rst(rst),
        .bus_io  (if_a)
    );

    spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) u_b (
        .FPGA_clk(clk),
        .FPGA_rst(rst),
        .bus_io  (if_b)
    );

    // Slave partner: MSB on SSEL fall, next bit after each SCLK fall.
    always @(negedge clk) begin
        sclk_p <= if_a.SCLK;
        ssel_p <= if_a.SSEL;
        if (ssel_p && !if_a.SSEL) sidx <= 5'd0;
        else if (sclk_p && !if_a.SCLK && !sidx[4]) sidx <= sidx + 5'd1;
    end
    always_comb slv_bit = sidx[4] ? 1'b0 : slv_word[4'd15 - sidx[3:0]];

    // Model: each frame is described by its cycle index t (t=1 is the cycle after acceptance).
    function automatic int dw_of(input int d);
        return (d == 0) ? 16 : 8;
    endfunction
    function automatic int cd_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    bit          m_act [2];
    int          m_t   [2];
    logic [15:0] m_tx  [2];
    logic [15:0] m_src [2];
    logic [15:0] m_rx  [2];
    logic        st_in [2];
    logic [15:0] tx_in [2];
    logic [15:0] src_in[2];
    int          cyc = 0;

    always_comb begin
        st_in[0]  = if_a.start;
        st_in[1]  = if_b.start;
        tx_in[0]  = if_a.tx_data;
        tx_in[1]  = {8'h00, if_b.tx_data};
        src_in[0] = loop_a ? if_a.tx_data : slv_word;
        src_in[1] = {8'h00, if_b.tx_data};
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d] <= 1'b0;
                m_t[d]   <= 0;
                m_tx[d]  <= '0;
                m_src[d] <= '0;
                m_rx[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_act[d]) begin
                    if (st_in[d]) begin
                        m_act[d] <= 1'b1;
                        m_t[d]   <= 1;
                        m_tx[d]  <= tx_in[d];
                        m_src[d] <= src_in[d];
                    end
                end else if (m_t[d] == (2 * dw_of(d) + 3) * cd_of(d)) begin
                    m_act[d] <= 1'b0;
                    m_t[d]   <= 0;
                end else begin
                    m_t[d] <= m_t[d] + 1;
                    if (m_t[d] + 1 == 1 + (2 * dw_of(d) + 2) * cd_of(d)) m_rx[d] <= m_src[d];
                end
            end
        end
    end

    // Expected {SCLK, SSEL, MOSI, busy, done} for frame cycle t.
    function automatic logic [4:0] exp_out(input int d, input bit act, input int t,
                                           input logic [15:0] tx);
        int dw, cd, idx;
        logic [15:0] sh;
        logic sclk, ssel, mosi, done;
        dw = dw_of(d);
        cd = cd_of(d);
        if (!act) return 5'b01000;
        ssel = (t > (2 * dw + 2) * cd);
        sclk = (t >= 1 + cd) && (t < 1 + cd + 2 * dw * cd) && (((t - 1 - cd) / cd) % 2 == 0);
        idx  = (t - 1) / (2 * cd);
        sh   = (idx < dw) ? (tx >> (dw - 1 - idx)) : 16'h0;
        mosi = (!ssel && idx < dw) ? sh[0] : 1'b0;
        done = (t == 1 + (2 * dw + 2) * cd);
        return {sclk, ssel, mosi, 1'b1, done};
    endfunction

    int          vectors = 0;
    int          miscompares = 0;
    int          rises = 0, lows = 0, done_a = 0, done_b = 0;
    int          done_cyc_a = 0, done_cyc_b = 0, hi_run = 0, last_gap = 0;
    bit          seen_low = 1'b0, mp_sclk = 1'b0;
    logic [15:0] mosi_cap = '0;
    int          acc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic run_frame_a(input logic [15:0] tx, input bit loop, input logic [15:0] slv,
                               input int chg_at, input logic [15:0] chg_val,
                               output int dcyc, output int nrise, output int nlow);
        int dn0, r0, l0;
        bit got;
        @(negedge clk);
        #1;
        loop_a       = loop;
        slv_word     = slv;
        if_a.tx_data = tx;
        if_a.start   = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        dn0 = done_a;
        r0  = rises;
        l0  = lows;
        got = 1'b0;
        for (int n = 1; n < 400 && !got; n++) begin
            @(negedge clk);
            #1;
            if (n == 1) if_a.start = 1'b0;
            if (n == chg_at) if_a.tx_data = chg_val;
            if (done_a != dn0) got = 1'b1;
        end
        check("frame_a_done_seen", {31'd0, got}, 32'd1);
        for (int k = 0; k < 50 && if_a.busy; k++) begin
            @(negedge clk);
            #1;
        end
        check("frame_a_idle", {31'd0, if_a.busy}, 32'd0);
        dcyc  = done_cyc_a - acc + 1;
        nrise = rises - r0;
        nlow  = lows - l0;
    endtask

    task automatic run_frame_b(input logic [7:0] tx, output int dcyc);
        int dn0;
        bit got;
        @(negedge clk);
        #1;
        if_b.tx_data = tx;
        if_b.start   = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        dn0 = done_b;
        got = 1'b0;
        for (int n = 1; n < 200 && !got; n++) begin
            @(negedge clk);
            #1;
            if (n == 1) if_b.start = 1'b0;
            if (done_b != dn0) got = 1'b1;
        end
        check("frame_b_done_seen", {31'd0, got}, 32'd1);
        for (int k = 0; k < 20 && if_b.busy; k++) begin
            @(negedge clk);
            #1;
        end
        dcyc = done_cyc_b - acc + 1;
    endtask

    initial begin
        int dc, nr, nl, dn0;
        rst          = 1'b1;
        loop_a       = 1'b1;
        slv_word     = 16'h0000;
        if_a.start   = 1'b0;
        if_a.tx_data = '0;
        if_b.start   = 1'b0;
        if_b.tx_data = '0;
        fork
            forever begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    logic [4:0]  e, a;
                    logic [15:0] r;
                    e = exp_out(d, m_act[d], m_t[d], m_tx[d]);
                    if (d == 0) begin
                        a = {if_a.SCLK, if_a.SSEL, if_a.MOSI, if_a.busy, if_a.done};
                        r = if_a.rx_data;
                    end else begin
                        a = {if_b.SCLK, if_b.SSEL, if_b.MOSI, if_b.busy, if_b.done};
                        r = {8'h00, if_b.rx_data};
                    end
                    vectors++;
                    if (a !== e || r !== m_rx[d]) begin
                        miscompares++;
                        $display("FAIL cycle dut%0d cyc %0d t %0d: sclk/ssel/mosi/busy/done %b rx %h, expected %b rx %h",
                                 d, cyc, m_t[d], a, r, e, m_rx[d]);
                    end
                end
                if (if_a.SCLK && !mp_sclk) begin
                    rises++;
                    mosi_cap = {mosi_cap[14:0], if_a.MOSI};
                end
                mp_sclk = if_a.SCLK;
                if (!if_a.SSEL) lows++;
                if (if_a.SSEL) hi_run++;
                else begin
                    if (seen_low && hi_run != 0) last_gap = hi_run;
                    hi_run   = 0;
                    seen_low = 1'b1;
                end
                if (if_a.done) begin
                    done_a++;
                    done_cyc_a = cyc;
                end
                if (if_b.done) begin
                    done_b++;
                    done_cyc_b = cyc;
                end
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                check("rst_ssel", {31'd0, if_a.SSEL}, 32'd1);
                check("rst_sclk_mosi_busy_done",
                      {28'd0, if_a.SCLK, if_a.MOSI, if_a.busy, if_a.done}, 32'd0);
                check("rst_rx", {16'd0, if_a.rx_data}, 32'd0);
                rst = 1'b0;

                run_frame_a(16'hA5C3, 1'b1, 16'h0, 0, 16'h0, dc, nr, nl);
                check("loop_rx", {16'd0, if_a.rx_data}, 32'hA5C3);
                check("loop_done_cycle", dc, 137);
                check("loop_sclk_rises", nr, 16);
                check("loop_ssel_low", nl, 136);
                check("loop_mosi_at_rises", {16'd0, mosi_cap}, 32'hA5C3);

                run_frame_a(16'hFFFF, 1'b0, 16'h3C5A, 0, 16'h0, dc, nr, nl);
                check("slave_rx", {16'd0, if_a.rx_data}, 32'h3C5A);
                check("slave_mosi_at_rises", {16'd0, mosi_cap}, 32'hFFFF);
                check("slave_done_cycle", dc, 137);

                run_frame_a(16'h1234, 1'b1, 16'h0, 5, 16'hFFFF, dc, nr, nl);
                check("txchg_mosi", {16'd0, mosi_cap}, 32'h1234);
                check("txchg_rx", {16'd0, if_a.rx_data}, 32'h1234);

                @(negedge clk);
                #1;
                loop_a       = 1'b1;
                if_a.tx_data = 16'h0F0F;
                if_a.start   = 1'b1;
                @(posedge clk);
                #1;
                dn0 = done_a;
                repeat (300) @(negedge clk);
                #1;
                if_a.start = 1'b0;
                for (int k = 0; k < 300 && if_a.busy; k++) begin
                    @(negedge clk);
                    #1;
                end
                check("held_done_count", done_a - dn0, 3);
                check("held_ssel_gap", last_gap, 5);
                check("held_rx", {16'd0, if_a.rx_data}, 32'h0F0F);

                @(negedge clk);
                #1;
                if_a.tx_data = 16'hA5C3;
                if_a.start   = 1'b1;
                @(posedge clk);
                #1;
                dn0 = done_a;
                for (int n = 1; n <= 60; n++) begin
                    @(negedge clk);
                    #1;
                    if (n == 1) if_a.start = 1'b0;
                end
                check("pre_rst_ssel", {31'd0, if_a.SSEL}, 32'd0);
                rst = 1'b1;
                #1;
                check("midrst_ssel", {31'd0, if_a.SSEL}, 32'd1);
                check("midrst_sclk_busy_done", {29'd0, if_a.SCLK, if_a.busy, if_a.done}, 32'd0);
                check("midrst_rx", {16'd0, if_a.rx_data}, 32'h0);
                @(posedge clk);
                #2;
                rst = 1'b0;
                repeat (200) @(negedge clk);
                #1;
                check("midrst_no_done", done_a - dn0, 0);
                run_frame_a(16'hC33C, 1'b1, 16'h0, 0, 16'h0, dc, nr, nl);
                check("post_rst_rx", {16'd0, if_a.rx_data}, 32'hC33C);
                check("post_rst_done_cycle", dc, 137);

                run_frame_b(8'h81, dc);
                check("b_rx_81", {24'd0, if_b.rx_data}, 32'h81);
                check("b_done_cycle", dc, 37);
                run_frame_b(8'h7E, dc);
                check("b_rx_7e", {24'd0, if_b.rx_data}, 32'h7E);
            end
            begin
                #1000000;
                miscompares++;
                $display("FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
